// File: rtl/bcrypt_pkg.sv
// Shared definitions for the bcrypt core: key-schedule FSM states, array
// sizes and the default SRAM location of the P-array.
package bcrypt_pkg;

   localparam int NUM_P                  = 18;
   localparam int NUM_S                  = 1024;
   localparam int NUM_PAIRS              = 521;
   localparam int P_ARRAY_OFFSET_DEFAULT = 4000;
   // w_idx value of the final pair; after it the schedule is complete.
   localparam int LAST_W_IDX             = 2 * NUM_PAIRS - 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      P_RD    = 3'd1,
      P_WR    = 3'd2,
      E_START = 3'd3,
      E_WAIT  = 3'd4,
      E_WR_L  = 3'd5,
      E_WR_R  = 3'd6,
      DONE    = 3'd7
   } ek_state_e;

endpackage

// File: rtl/ek_addr_map.sv
// Maps a key-schedule write index onto the SRAM word address:
// the first 18 indices land in the P-array, the rest in the S-boxes from 0.
module ek_addr_map
   import bcrypt_pkg::*;
#(
   parameter int OFFSET = P_ARRAY_OFFSET_DEFAULT
) (
   input  logic [10:0] idx_i,
   output logic [11:0] addr_o
);

   localparam logic [11:0] OFFSET_W = 12'(OFFSET);
   localparam logic [10:0] NUM_P_W  = 11'(NUM_P);

   logic [10:0] s_idx;

   always_comb begin
      s_idx = idx_i - NUM_P_W;
      if (idx_i < NUM_P_W) begin
         addr_o = OFFSET_W + {1'b0, idx_i};
      end else begin
         addr_o = {1'b0, s_idx};
      end
   end

endmodule

// File: rtl/expand_key.sv
// Blowfish/EksBlowfish key-schedule controller: XORs the key into P, then
// drives 521 chained feistel encryptions and writes results to both SRAMs.
module expand_key
   import bcrypt_pkg::*;
#(
   parameter int P_ARRAY_OFFSET = P_ARRAY_OFFSET_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_l,
   input  logic         start,
   input  logic [4:0]   key_words,
   output logic [4:0]   key_addr,
   input  logic [31:0]  key_word,
   input  logic         salt_en,
   input  logic [127:0] salt,
   output logic         fs_start,
   output logic [31:0]  fs_L,
   output logic [31:0]  fs_R,
   input  logic [31:0]  fs_resultL,
   input  logic [31:0]  fs_resultR,
   input  logic         fs_done,
   output logic         sram_own,
   output logic [11:0]  addr_a,
   output logic [11:0]  addr_b,
   output logic [31:0]  wdata,
   input  logic [31:0]  data_a,
   output logic         cs_a_l,
   output logic         we_a_l,
   output logic         oe_a_l,
   output logic         cs_b_l,
   output logic         we_b_l,
   output logic         oe_b_l,
   output logic         busy,
   output logic         done,
   output logic [2:0]   dbg_state
);

   localparam logic [11:0] OFFSET_W = 12'(P_ARRAY_OFFSET);
   localparam logic [4:0]  NUM_P_W  = 5'(NUM_P);
   localparam logic [4:0]  LAST_P   = 5'(NUM_P - 1);
   localparam logic [10:0] LAST_W   = 11'(LAST_W_IDX);

   ek_state_e   state_q;
   logic [4:0]  p_idx_q;
   logic [4:0]  k_idx_q;
   logic [4:0]  kw_q;
   logic [10:0] w_idx_q;
   logic        salt_en_q;
   logic [31:0] l_q;
   logic [31:0] r_q;

   logic [4:0]  kw_clamped;
   logic [10:0] map_idx;
   logic [11:0] w_addr;
   logic [11:0] p_addr;
   logic [31:0] salt_l;
   logic [31:0] salt_r;

   assign kw_clamped = (key_words == 5'd0 || key_words > NUM_P_W) ? NUM_P_W : key_words;
   assign p_addr     = OFFSET_W + {7'd0, p_idx_q};
   // E_WR_R stores the right half one slot above the left half.
   assign map_idx    = w_idx_q + {10'd0, state_q == E_WR_R};

   ek_addr_map #(.OFFSET(P_ARRAY_OFFSET)) u_addr_map (
      .idx_i  (map_idx),
      .addr_o (w_addr)
   );

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q   <= IDLE;
         p_idx_q   <= '0;
         k_idx_q   <= '0;
         kw_q      <= NUM_P_W;
         w_idx_q   <= '0;
         salt_en_q <= 1'b0;
         l_q       <= '0;
         r_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  salt_en_q <= salt_en;
                  kw_q      <= kw_clamped;
                  p_idx_q   <= '0;
                  k_idx_q   <= '0;
                  w_idx_q   <= '0;
                  l_q       <= '0;
                  r_q       <= '0;
                  state_q   <= P_RD;
               end
            end
            P_RD: state_q <= P_WR;
            P_WR: begin
               k_idx_q <= (k_idx_q == kw_q - 5'd1) ? 5'd0 : k_idx_q + 5'd1;
               if (p_idx_q == LAST_P) begin
                  state_q <= E_START;
               end else begin
                  p_idx_q <= p_idx_q + 5'd1;
                  state_q <= P_RD;
               end
            end
            E_START: state_q <= E_WAIT;
            E_WAIT: begin
               if (fs_done) begin
                  l_q     <= fs_resultL;
                  r_q     <= fs_resultR;
                  state_q <= E_WR_L;
               end
            end
            E_WR_L: state_q <= E_WR_R;
            E_WR_R: begin
               w_idx_q <= w_idx_q + 11'd2;
               state_q <= (w_idx_q == LAST_W) ? DONE : E_START;
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Salt words 0/1 go with even pairs, words 2/3 with odd pairs.
   always_comb begin
      salt_l = '0;
      salt_r = '0;
      if (state_q == E_START && salt_en_q) begin
         salt_l = w_idx_q[1] ? salt[63:32] : salt[127:96];
         salt_r = w_idx_q[1] ? salt[31:0]  : salt[95:64];
      end
   end

   always_comb begin
      cs_a_l   = 1'b1;
      we_a_l   = 1'b1;
      oe_a_l   = 1'b0;
      cs_b_l   = 1'b1;
      we_b_l   = 1'b1;
      oe_b_l   = 1'b0;
      addr_a   = '0;
      addr_b   = '0;
      wdata    = '0;
      fs_start = 1'b0;
      sram_own = 1'b1;
      case (state_q)
         P_RD: begin
            cs_a_l = 1'b0;
            addr_a = p_addr;
         end
         P_WR: begin
            cs_a_l = 1'b0;
            cs_b_l = 1'b0;
            we_a_l = 1'b0;
            we_b_l = 1'b0;
            oe_a_l = 1'b1;
            oe_b_l = 1'b1;
            addr_a = p_addr;
            addr_b = p_addr;
            wdata  = data_a ^ key_word;
         end
         E_START: begin
            fs_start = 1'b1;
            sram_own = 1'b0;
         end
         E_WAIT: sram_own = 1'b0;
         E_WR_L, E_WR_R: begin
            cs_a_l = 1'b0;
            cs_b_l = 1'b0;
            we_a_l = 1'b0;
            we_b_l = 1'b0;
            oe_a_l = 1'b1;
            oe_b_l = 1'b1;
            addr_a = w_addr;
            addr_b = w_addr;
            wdata  = (state_q == E_WR_L) ? l_q : r_q;
         end
         default: ;
      endcase
   end

   assign fs_L      = l_q ^ salt_l;
   assign fs_R      = r_q ^ salt_r;
   assign key_addr  = k_idx_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_expand_key.sv
// Directed bench for expand_key with mirrored SRAM models and a feistel stub.
module tb_expand_key;

   localparam logic [2:0] ST_IDLE = 3'd0, ST_P_RD = 3'd1, ST_P_WR = 3'd2,
                          ST_E_START = 3'd3, ST_E_WAIT = 3'd4;

   logic         clk = 1'b0;
   logic         reset_l = 1'b1;
   logic         start = 1'b0;
   logic [4:0]   key_words = 5'd1;
   logic [4:0]   key_addr;
   logic [31:0]  key_word;
   logic         salt_en = 1'b0;
   logic [127:0] salt = '0;
   logic         fs_start;
   logic [31:0]  fs_L, fs_R, fs_resultL, fs_resultR;
   logic         fs_done;
   logic         sram_own;
   logic [11:0]  addr_a, addr_b;
   logic [31:0]  wdata;
   logic [31:0]  data_a;
   logic         cs_a_l, we_a_l, oe_a_l, cs_b_l, we_b_l, oe_b_l;
   logic         busy, done;
   logic [2:0]   dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] key_mem [0:31];
   logic [31:0] mem_a [0:4095];
   logic [31:0] mem_b [0:4095];
   logic [31:0] pre_p [0:17];
   logic        do_preload = 1'b0;
   logic        stub_ident = 1'b0;
   int          stub_d = 4;
   int          stub_cnt;
   logic        force_done = 1'b0;
   logic [31:0] res_l, res_r;

   expand_key dut (
      .clk(clk), .reset_l(reset_l), .start(start), .key_words(key_words),
      .key_addr(key_addr), .key_word(key_word), .salt_en(salt_en), .salt(salt),
      .fs_start(fs_start), .fs_L(fs_L), .fs_R(fs_R), .fs_resultL(fs_resultL),
      .fs_resultR(fs_resultR), .fs_done(fs_done), .sram_own(sram_own),
      .addr_a(addr_a), .addr_b(addr_b), .wdata(wdata), .data_a(data_a),
      .cs_a_l(cs_a_l), .we_a_l(we_a_l), .oe_a_l(oe_a_l), .cs_b_l(cs_b_l),
      .we_b_l(we_b_l), .oe_b_l(oe_b_l), .busy(busy), .done(done),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   assign key_word = key_mem[key_addr];

   // Two SRAMs; A returns read data the cycle after the address.
   always @(posedge clk) begin
      if (do_preload) begin
         for (int i = 0; i < 18; i++) begin
            mem_a[4000 + i] <= pre_p[i];
            mem_b[4000 + i] <= pre_p[i];
         end
      end
      if (!cs_a_l && !we_a_l) mem_a[addr_a] <= wdata;
      if (!cs_a_l && we_a_l) data_a <= mem_a[addr_a];
      if (!cs_b_l && !we_b_l) mem_b[addr_b] <= wdata;
   end

   // Feistel stand-in: L+1/R+2 or identity, fs_done in the stub_d-th wait cycle.
   always @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         stub_cnt <= 0;
         res_l    <= '0;
         res_r    <= '0;
      end else if (fs_start) begin
         stub_cnt <= stub_d;
         res_l    <= stub_ident ? fs_L : fs_L + 32'd1;
         res_r    <= stub_ident ? fs_R : fs_R + 32'd2;
      end else if (stub_cnt != 0) begin
         stub_cnt <= stub_cnt - 1;
      end
   end

   assign fs_done    = (stub_cnt == 1) | force_done;
   assign fs_resultL = res_l;
   assign fs_resultR = res_r;

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic tick_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic do_reset();
      @(negedge clk);
      start = 1'b0;
      force_done = 1'b0;
      reset_l = 1'b0;
      @(negedge clk);
      reset_l = 1'b1;
   endtask

   task automatic preload(input logic [31:0] base, input logic [31:0] step);
      for (int i = 0; i < 18; i++) pre_p[i] = base + step * i;
      @(negedge clk);
      do_preload = 1'b1;
      @(negedge clk);
      do_preload = 1'b0;
   endtask

   // Leaves the bench at the negedge of cycle 1 (first cycle after start).
   task automatic start_run(input logic [4:0] kw, input logic se);
      @(negedge clk);
      key_words = kw;
      salt_en = se;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
   endtask

   task automatic test_reset();
      start_run(5'd1, 1'b0);
      tick_to(3);
      #2 reset_l = 1'b0;
      #1;
      checks++;
      if ({busy, done, fs_start, sram_own} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_ctrl got busy/done/fs_start/sram_own=%b want 0001",
                  {busy, done, fs_start, sram_own});
      end
      checks++;
      if ({cs_a_l, we_a_l, oe_a_l, cs_b_l, we_b_l, oe_b_l} !== 6'b110110) begin
         errors++;
         $display("FAIL reset_strobes got %b want 110110",
                  {cs_a_l, we_a_l, oe_a_l, cs_b_l, we_b_l, oe_b_l});
      end
      checks++;
      if ({addr_a, addr_b, wdata, fs_L, fs_R, key_addr} !== '0) begin
         errors++;
         $display("FAIL reset_buses got addr_a=%0d addr_b=%0d wdata=%h fs_L=%h fs_R=%h key_addr=%0d want all 0",
                  addr_a, addr_b, wdata, fs_L, fs_R, key_addr);
      end
      checks++;
      if (dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done_low got %b want 0", done);
         end
      end
      reset_l = 1'b1;
   endtask

   task automatic test_p_xor();
      preload(32'd0, 32'd1);
      key_mem[0] = 32'hA5A5_A5A5;
      stub_ident = 1'b0;
      stub_d = 4;
      start_run(5'd1, 1'b0);
      checks++;
      if (dbg_state !== ST_P_RD || cs_a_l !== 1'b0 || addr_a !== 12'd4000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL p_first_read got state=%0d cs_a_l=%b addr_a=%0d busy=%b want 1/0/4000/1",
                  dbg_state, cs_a_l, addr_a, busy);
      end
      tick();
      checks++;
      if (dbg_state !== ST_P_WR || wdata !== 32'hA5A5_A5A5 || we_a_l !== 1'b0 ||
          we_b_l !== 1'b0 || addr_b !== 12'd4000) begin
         errors++;
         $display("FAIL p_first_write got state=%0d wdata=%h we_a=%b we_b=%b addr_b=%0d want 2/a5a5a5a5/0/0/4000",
                  dbg_state, wdata, we_a_l, we_b_l, addr_b);
      end
      tick_to(37);
      checks++;
      if (dbg_state !== ST_E_START || fs_start !== 1'b1 || sram_own !== 1'b0) begin
         errors++;
         $display("FAIL p_phase_end got state=%0d fs_start=%b sram_own=%b want 3/1/0",
                  dbg_state, fs_start, sram_own);
      end
      for (int i = 0; i < 18; i++) begin
         checks++;
         if (mem_a[4000 + i] !== (i ^ 32'hA5A5_A5A5) || mem_b[4000 + i] !== (i ^ 32'hA5A5_A5A5)) begin
            errors++;
            $display("FAIL p_xor[%0d] got a=%h b=%h want %h", i, mem_a[4000 + i],
                     mem_b[4000 + i], i ^ 32'hA5A5_A5A5);
         end
      end
      do_reset();
   endtask

   task automatic test_key_wrap();
      preload(32'd0, 32'd0);
      key_mem[0] = 32'h1111_1111;
      key_mem[1] = 32'h2222_2222;
      key_mem[2] = 32'h3333_3333;
      key_mem[3] = 32'hDEAD_BEEF;
      start_run(5'd3, 1'b0);
      tick_to(37);
      checks++;
      if (mem_a[4017] !== 32'h3333_3333 || mem_b[4017] !== 32'h3333_3333) begin
         errors++;
         $display("FAIL wrap_p17 got a=%h b=%h want 33333333", mem_a[4017], mem_b[4017]);
      end
      checks++;
      if (mem_a[4003] !== 32'h1111_1111 || mem_b[4003] !== 32'h1111_1111) begin
         errors++;
         $display("FAIL wrap_p3 got a=%h b=%h want 11111111", mem_a[4003], mem_b[4003]);
      end
      checks++;
      if (mem_a[4004] !== 32'h2222_2222) begin
         errors++;
         $display("FAIL wrap_p4 got %h want 22222222", mem_a[4004]);
      end
      do_reset();
   endtask

   task automatic test_chain();
      int first_done;
      int nstarts;
      first_done = -1;
      nstarts = 0;
      stub_ident = 1'b0;
      stub_d = 4;
      start_run(5'd1, 1'b0);
      for (int i = 0; i < 5000 && first_done < 0; i++) begin
         if (fs_start === 1'b1) begin
            nstarts++;
            if (nstarts == 1) begin
               checks++;
               if (fs_L !== 32'd0 || fs_R !== 32'd0) begin
                  errors++;
                  $display("FAIL chain_in0 got %h/%h want 0/0", fs_L, fs_R);
               end
            end
            if (nstarts == 2) begin
               checks++;
               if (fs_L !== 32'd1 || fs_R !== 32'd2) begin
                  errors++;
                  $display("FAIL chain_in1 got %h/%h want 1/2", fs_L, fs_R);
               end
            end
         end
         if (done === 1'b1) first_done = cyc;
         else tick();
      end
      checks++;
      if (first_done != 3684) begin
         errors++;
         $display("FAIL chain_done_cycle got %0d want 3684", first_done);
      end
      checks++;
      if (nstarts != 521 || busy !== 1'b1) begin
         errors++;
         $display("FAIL chain_pairs got starts=%0d busy=%b want 521/1", nstarts, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL chain_after_done got done=%b busy=%b state=%0d want 0/0/0",
                  done, busy, dbg_state);
      end
      checks++;
      if (mem_a[4000] !== 32'd1 || mem_a[4001] !== 32'd2 || mem_b[4000] !== 32'd1 || mem_b[4001] !== 32'd2) begin
         errors++;
         $display("FAIL chain_p01 got a=%h/%h b=%h/%h want 1/2", mem_a[4000], mem_a[4001],
                  mem_b[4000], mem_b[4001]);
      end
      checks++;
      if (mem_a[4017] !== 32'd18 || mem_a[0] !== 32'd10 || mem_b[0] !== 32'd10) begin
         errors++;
         $display("FAIL chain_p17_s0 got p17=%0d s0a=%0d s0b=%0d want 18/10/10",
                  mem_a[4017], mem_a[0], mem_b[0]);
      end
      checks++;
      if (mem_a[1023] !== 32'd1042 || mem_b[1023] !== 32'd1042) begin
         errors++;
         $display("FAIL chain_s1023 got a=%0d b=%0d want 1042", mem_a[1023], mem_b[1023]);
      end
   endtask

   task automatic test_salt();
      logic [31:0] got_l [0:2];
      logic [31:0] got_r [0:2];
      logic [31:0] exp_l [0:2];
      logic [31:0] exp_r [0:2];
      int n;
      exp_l = '{32'd1, 32'd2, 32'd3};
      exp_r = '{32'd2, 32'd6, 32'd4};
      for (int i = 0; i < 3; i++) begin
         got_l[i] = 32'hFFFF_FFFF;
         got_r[i] = 32'hFFFF_FFFF;
      end
      n = 0;
      salt = 128'h00000001_00000002_00000003_00000004;
      stub_ident = 1'b1;
      stub_d = 1;
      start_run(5'd1, 1'b1);
      for (int i = 0; i < 200 && n < 3; i++) begin
         if (fs_start === 1'b1) begin
            got_l[n] = fs_L;
            got_r[n] = fs_R;
            n++;
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
            errors++;
            $display("FAIL salt_pair%0d got %h/%h want %h/%h", i, got_l[i], got_r[i],
                     exp_l[i], exp_r[i]);
         end
      end
      do_reset();
      salt_en = 1'b0;
   endtask

   task automatic test_robustness();
      stub_ident = 1'b0;
      stub_d = 4;
      start_run(5'd1, 1'b0);
      tick_to(2);
      force_done = 1'b1;
      tick();
      force_done = 1'b0;
      checks++;
      if (dbg_state !== ST_P_RD || cyc != 3) begin
         errors++;
         $display("FAIL fs_done_in_p_wr got state=%0d want %0d", dbg_state, ST_P_RD);
      end
      tick_to(38);
      checks++;
      if (dbg_state !== ST_E_WAIT) begin
         errors++;
         $display("FAIL robust_reach_wait got state=%0d want %0d", dbg_state, ST_E_WAIT);
      end
      start = 1'b1;
      key_words = 5'd5;
      tick();
      start = 1'b0;
      checks++;
      if (dbg_state !== ST_E_WAIT || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_in_wait got state=%0d busy=%b want %0d/1", dbg_state, busy, ST_E_WAIT);
      end
      #2 reset_l = 1'b0;
      @(negedge clk);
      reset_l = 1'b1;
      start_run(5'd1, 1'b0);
      checks++;
      if (dbg_state !== ST_P_RD || cs_a_l !== 1'b0 || addr_a !== 12'd4000) begin
         errors++;
         $display("FAIL restart_after_reset got state=%0d cs_a_l=%b addr_a=%0d want 1/0/4000",
                  dbg_state, cs_a_l, addr_a);
      end
      do_reset();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) key_mem[i] = 32'd0;
      #1 reset_l = 1'b0;
      #20 reset_l = 1'b1;
      test_reset();
      test_p_xor();
      test_key_wrap();
      test_salt();
      test_robustness();
      test_chain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
